// File: rtl/oam_sprite_evaluator_if.sv
// OAM evaluator bus bundle.
//   read_addr / read_data : OAM read port (data valid one cycle after address)
//   out_valid / out_ready : sprite record stream handshake
//   spr_index, spr_x, spr_attr, spr_tile, spr_row : sprite record payload
// master = evaluator side, slave = OAM memory / line-buffer fill side.
interface oam_sprite_evaluator_if #(
  parameter int ROW_W = 3
);
  logic [5:0]       read_addr;
  logic [31:0]      read_data;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       spr_index;
  logic [7:0]       spr_x;
  logic [7:0]       spr_attr;
  logic [7:0]       spr_tile;
  logic [ROW_W-1:0] spr_row;

  modport master (
    output read_addr,
    input  read_data,
    output out_valid,
    input  out_ready,
    output spr_index, spr_x, spr_attr, spr_tile, spr_row
  );

  modport slave (
    input  read_addr,
    output read_data,
    input  out_valid,
    output out_ready,
    input  spr_index, spr_x, spr_attr, spr_tile, spr_row
  );
endinterface

// File: rtl/oam_sprite_evaluator.sv
// OAM sprite evaluator.
// Once per scanline, scans all 64 OAM entries through the read port,
// keeps up to MAX_SPRITES entries that intersect the scanline and streams
// them in ascending OAM index order over a valid/ready handshake.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   start        : 1-cycle evaluation request, honoured only when idle
//   scanline     : line to evaluate, sampled with an accepted start
//   bus          : OAM read port + sprite record stream (master modport)
//   busy         : high whenever not idle
//   done         : 1-cycle pulse after the last record is accepted
//   sprite_count : records produced for the scanline
//   overflow     : more than MAX_SPRITES hits on the scanline
// Entry format: [7:0] Y, [15:8] tile, [23:16] attr, [31:24] X.
module oam_sprite_evaluator #(
  parameter int SPRITE_HEIGHT = 8,
  parameter int MAX_SPRITES   = 8,
  localparam int ROW_W        = $clog2(SPRITE_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    scanline,
  oam_sprite_evaluator_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic [4:0]                    sprite_count,
  output logic                          overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  typedef struct packed {
    logic [5:0]       index;
    logic [7:0]       x;
    logic [7:0]       attr;
    logic [7:0]       tile;
    logic [ROW_W-1:0] row;
  } rec_t;

  state_t     state;
  logic [7:0] line_q;
  logic [5:0] read_addr_q;
  logic       cmp_valid;   // read_data this cycle belongs to cmp_index
  logic [5:0] cmp_index;
  logic [4:0] count;
  logic [4:0] ptr;
  logic       out_valid_q;
  rec_t       out_rec;
  // Sized for the largest legal MAX_SPRITES; only the first MAX_SPRITES
  // entries are ever written.
  rec_t       buffer [16];

  logic [7:0] y;
  logic [7:0] diff;
  logic       hit;
  logic       store;
  rec_t       cur_rec;
  logic [4:0] count_nx;
  logic [4:0] ptr_nx;

  always_comb begin
    y        = bus.read_data[7:0];
    diff     = line_q - y;
    hit      = cmp_valid && (line_q >= y) && (diff < 8'(SPRITE_HEIGHT));
    store    = hit && (count < 5'(MAX_SPRITES));
    count_nx = count + 5'(store);
    ptr_nx   = ptr + 5'd1;
    cur_rec  = '{index: cmp_index,
                 x:     bus.read_data[31:24],
                 attr:  bus.read_data[23:16],
                 tile:  bus.read_data[15:8],
                 row:   diff[ROW_W-1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      line_q      <= '0;
      read_addr_q <= '0;
      cmp_valid   <= 1'b0;
      cmp_index   <= '0;
      count       <= '0;
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_rec     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            line_q      <= scanline;
            count       <= '0;
            overflow    <= 1'b0;
            read_addr_q <= '0;
            cmp_valid   <= 1'b0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end

        SCAN: begin
          if (store) begin
            buffer[count[3:0]] <= cur_rec;
            count              <= count_nx;
          end
          if (hit && !store) overflow <= 1'b1;
          cmp_valid <= 1'b1;
          cmp_index <= read_addr_q;
          if (read_addr_q != 6'd63) read_addr_q <= read_addr_q + 6'd1;

          if (cmp_valid && cmp_index == 6'd63) begin
            cmp_valid <= 1'b0;
            if (count_nx == 5'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // The first record may be the hit being stored this very
              // cycle, so bypass the buffer in that case.
              out_rec     <= (count == 5'd0) ? cur_rec : buffer[0];
              out_valid_q <= 1'b1;
              ptr         <= '0;
              state       <= EMIT;
            end
          end
        end

        EMIT: begin
          if (out_valid_q && bus.out_ready) begin
            if (ptr_nx < count) begin
              ptr     <= ptr_nx;
              out_rec <= buffer[ptr_nx[3:0]];
            end else begin
              out_valid_q <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_addr = read_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.spr_index = out_rec.index;
  assign bus.spr_x     = out_rec.x;
  assign bus.spr_attr  = out_rec.attr;
  assign bus.spr_tile  = out_rec.tile;
  assign bus.spr_row   = out_rec.row;
  assign sprite_count  = count;

endmodule

// File: tb/tb_oam_sprite_evaluator.sv
// Directed bench for oam_sprite_evaluator: one 8-line instance (main checks)
// and one 16-line instance (tall-sprite boundary), sharing one OAM model.
module tb_oam_sprite_evaluator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start16 = 1'b0;
  logic [7:0] scanline = 8'd0;

  logic       busy, done, overflow;
  logic [4:0] sprite_count;
  logic       busy16, done16, overflow16;
  logic [4:0] sprite_count16;

  oam_sprite_evaluator_if #(.ROW_W(3)) b8 ();
  oam_sprite_evaluator_if #(.ROW_W(4)) b16 ();

  oam_sprite_evaluator #(.SPRITE_HEIGHT(8), .MAX_SPRITES(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .scanline(scanline), .bus(b8),
    .busy(busy), .done(done), .sprite_count(sprite_count), .overflow(overflow)
  );

  oam_sprite_evaluator #(.SPRITE_HEIGHT(16), .MAX_SPRITES(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .scanline(scanline), .bus(b16),
    .busy(busy16), .done(done16), .sprite_count(sprite_count16), .overflow(overflow16)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) begin
    b8.read_data  <= mem[b8.read_addr];
    b16.read_data <= mem[b16.read_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [7:0] yv, input logic [7:0] tile,
                                      input logic [7:0] attr, input logic [7:0] xv);
    return {xv, attr, tile, yv};
  endfunction

  function automatic logic [33:0] rec(input logic [5:0] idx, input logic [7:0] xv,
                                      input logic [7:0] attr, input logic [7:0] tile,
                                      input logic [3:0] row);
    return {idx, xv, attr, tile, row};
  endfunction

  function automatic logic [33:0] pk8();
    return {b8.spr_index, b8.spr_x, b8.spr_attr, b8.spr_tile, 1'b0, b8.spr_row};
  endfunction

  function automatic logic [33:0] pk16();
    return {b16.spr_index, b16.spr_x, b16.spr_attr, b16.spr_tile, b16.spr_row};
  endfunction

  // Transfer / stall monitor, sampled on the active edge before DUT update.
  logic [33:0] q8[$];
  logic [33:0] q16[$];
  int          done8_cnt = 0;
  int          valid8_cnt = 0;
  logic [33:0] held = '0;
  bit          stalled = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      if (done) done8_cnt++;
      if (b8.out_valid) valid8_cnt++;
      if (stalled && b8.out_valid) chk("stall_hold", pk8(), held);
      stalled = b8.out_valid && !b8.out_ready;
      held    = pk8();
      if (b8.out_valid && b8.out_ready) q8.push_back(pk8());
      if (b16.out_valid && b16.out_ready) q16.push_back(pk16());
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic [7:0] yv);
    for (int i = 0; i < 64; i++) mem[i] = ent(yv, 8'(i + 100), 8'(i), 8'(3 * i));
  endtask

  // Run one evaluation on the 8-line instance; lat = negedges from the
  // start-drive edge to the first edge where done is seen.
  task automatic run8(input logic [7:0] line, input bit rnd, input bit poke, output int lat);
    q8.delete();
    done8_cnt  = 0;
    valid8_cnt = 0;
    @(negedge clk);
    scanline = line;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 3000) begin
      b8.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && busy && !done && (lat == 30 || lat == 70)) begin
        start    = 1'b1;
        scanline = 8'd200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start        = 1'b0;
    b8.out_ready = 1'b1;
    chk("done_seen", 34'(done), 34'd1);
    @(negedge clk);
    chk("busy_after_done", 34'(busy), 34'd0);
    chk("done_one_cycle", 34'(done), 34'd0);
    chk("done_pulse_count", 34'(done8_cnt), 34'd1);
  endtask

  task automatic check_reset();
    chk("rst_read_addr", 34'(b8.read_addr), 34'd0);
    chk("rst_out_valid", 34'(b8.out_valid), 34'd0);
    chk("rst_fields", pk8(), 34'd0);
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_done", 34'(done), 34'd0);
    chk("rst_count", 34'(sprite_count), 34'd0);
    chk("rst_overflow", 34'(overflow), 34'd0);
  endtask

  task automatic check_full8();
    chk("full_nrec", 34'(q8.size()), 34'd8);
    for (int i = 0; i < 8; i++)
      chk("full_rec", (i < q8.size()) ? q8[i] : '1,
          rec(6'(i), 8'(3 * i), 8'(i), 8'(i + 100), 4'd2));
    chk("full_count", 34'(sprite_count), 34'd8);
    chk("full_overflow", 34'(overflow), 34'd1);
  endtask

  initial begin
    int lat;
    b8.out_ready  = 1'b1;
    b16.out_ready = 1'b1;
    fill(8'hF0);
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b1;
    @(negedge clk);

    // No hits: minimum latency, no records.
    run8(8'd20, 1'b0, 1'b0, lat);
    chk("nohit_latency", 34'(lat), 34'd66);
    chk("nohit_nrec", 34'(q8.size()), 34'd0);
    chk("nohit_valid_cycles", 34'(valid8_cnt), 34'd0);
    chk("nohit_count", 34'(sprite_count), 34'd0);
    chk("nohit_overflow", 34'(overflow), 34'd0);
    chk("read_addr_hold", 34'(b8.read_addr), 34'd63);

    // Two hits, ascending index order.
    mem[3]  = ent(8'd16, 8'h12, 8'h81, 8'h40);
    mem[60] = ent(8'd20, 8'h34, 8'h02, 8'h55);
    run8(8'd20, 1'b0, 1'b0, lat);
    chk("two_nrec", 34'(q8.size()), 34'd2);
    chk("two_rec0", (q8.size() > 0) ? q8[0] : '1, rec(6'd3, 8'h40, 8'h81, 8'h12, 4'd4));
    chk("two_rec1", (q8.size() > 1) ? q8[1] : '1, rec(6'd60, 8'h55, 8'h02, 8'h34, 4'd0));
    chk("two_count", 34'(sprite_count), 34'd2);
    chk("two_overflow", 34'(overflow), 34'd0);

    // All entries hit: capped at 8, overflow; random backpressure and
    // ignored starts while busy.
    fill(8'd10);
    run8(8'd12, 1'b1, 1'b1, lat);
    check_full8();

    // Boundaries on line 20 (8-line): Y=13 hit row 7; Y=12, 21, 5, 4 miss.
    fill(8'hF0);
    mem[5]  = ent(8'd13, 8'h21, 8'h31, 8'h41);
    mem[6]  = ent(8'd12, 8'h22, 8'h32, 8'h42);
    mem[7]  = ent(8'd21, 8'h23, 8'h33, 8'h43);
    mem[11] = ent(8'd4,  8'h24, 8'h34, 8'h44);
    mem[12] = ent(8'd5,  8'h25, 8'h35, 8'h45);
    run8(8'd20, 1'b0, 1'b0, lat);
    chk("bnd8_nrec", 34'(q8.size()), 34'd1);
    chk("bnd8_rec", (q8.size() > 0) ? q8[0] : '1, rec(6'd5, 8'h41, 8'h31, 8'h21, 4'd7));

    // Same table, 16-line instance: Y=13 row 7, Y=12 row 8, Y=5 row 15.
    q16.delete();
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 3000 && !done16; i++) @(negedge clk);
    chk("bnd16_done", 34'(done16), 34'd1);
    chk("bnd16_nrec", 34'(q16.size()), 34'd3);
    chk("bnd16_rec0", (q16.size() > 0) ? q16[0] : '1, rec(6'd5, 8'h41, 8'h31, 8'h21, 4'd7));
    chk("bnd16_rec1", (q16.size() > 1) ? q16[1] : '1, rec(6'd6, 8'h42, 8'h32, 8'h22, 4'd8));
    chk("bnd16_rec2", (q16.size() > 2) ? q16[2] : '1, rec(6'd12, 8'h45, 8'h35, 8'h25, 4'd15));
    chk("bnd16_count", 34'(sprite_count16), 34'd3);
    @(negedge clk);

    // No wrap: Y=250 misses line 4, Y=0 hits it with row 4.
    fill(8'hF0);
    mem[9]  = ent(8'd250, 8'h11, 8'h22, 8'h33);
    mem[10] = ent(8'd0,   8'h44, 8'h55, 8'h66);
    run8(8'd4, 1'b0, 1'b0, lat);
    chk("wrap_nrec", 34'(q8.size()), 34'd1);
    chk("wrap_rec", (q8.size() > 0) ? q8[0] : '1, rec(6'd10, 8'h66, 8'h55, 8'h44, 4'd4));

    // Reset mid-SCAN, then a clean full evaluation.
    fill(8'd10);
    @(negedge clk);
    scanline = 8'd12;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    reset = 1'b1;
    run8(8'd12, 1'b0, 1'b0, lat);
    check_full8();

    // Reset mid-EMIT while stalled, then a clean full evaluation.
    @(negedge clk);
    b8.out_ready = 1'b0;
    scanline     = 8'd12;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !b8.out_valid; i++) @(negedge clk);
    chk("emit_reached", 34'(b8.out_valid), 34'd1);
    chk("emit_count", 34'(sprite_count), 34'd8);
    reset = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    reset        = 1'b1;
    b8.out_ready = 1'b1;
    run8(8'd12, 1'b1, 1'b0, lat);
    check_full8();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
